// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the sync_fifo block.
package sync_fifo_pkg;
    localparam int WIDTH_DEFAULT = 32;
    localparam int DEPTH_DEFAULT = 7;
endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo.
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic [WIDTH-1:0] data_in;
    logic             insert;
    logic             remove;
    logic             flush;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;

    modport master (
        output data_in, insert, remove, flush,
        input  data_out, full, empty
    );

    modport slave (
        input  data_in, insert, remove, flush,
        output data_out, full, empty
    );
endinterface

// File: rtl/sync_fifo_mem.sv
// Simple dual-port array: synchronous write, registered read that holds
// its value when no read is requested.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             we,
    input  logic [DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [DEPTH-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [2**DEPTH];

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk_in) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer/count control with flush; storage in sync_fifo_mem.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic       clk_in,
    input  logic       reset,
    sync_fifo_if.slave bus
);
    localparam logic [DEPTH:0] CAP = {1'b1, {DEPTH{1'b0}}};

    logic [DEPTH-1:0] wptr, rptr;
    logic [DEPTH:0]   count;
    logic             do_wr, do_rd;

    // Flags come straight from the registered count, never from the strobes.
    assign bus.full  = (count == CAP);
    assign bus.empty = (count == '0);

    assign do_wr = bus.insert & ~bus.full  & ~bus.flush;
    assign do_rd = bus.remove & ~bus.empty & ~bus.flush;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (bus.flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    sync_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk_in (clk_in),
        .reset  (reset),
        .we     (do_wr),
        .waddr  (wptr),
        .wdata  (bus.data_in),
        .re     (do_rd),
        .raddr  (rptr),
        .rdata  (bus.data_out)
    );
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: queue-based reference model checked every
// cycle, plus literal expectations on the directed scenarios.
module tb_sync_fifo;
    localparam int W   = 32;
    localparam int D   = 7;
    localparam int CAP = 1 << D;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_in = ~clk_in;

    sync_fifo_if #(.WIDTH(W)) bus ();

    sync_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    int          errs   = 0;
    int          checks = 0;
    bit          chk_en = 1'b0;
    logic [W-1:0] mq[$];
    logic [W-1:0] m_dout = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("model_dout",  bus.data_out, m_dout);
            chk("model_full",  {31'd0, bus.full},  {31'd0, mq.size() == CAP});
            chk("model_empty", {31'd0, bus.empty}, {31'd0, mq.size() == 0});
        end
    end

    // One clock cycle of stimulus; model advances from the pre-edge state.
    task automatic step(input bit ins, input bit rem, input bit fl, input logic [W-1:0] d);
        bit can_wr, can_rd;
        @(negedge clk_in);
        bus.insert  = ins;
        bus.remove  = rem;
        bus.flush   = fl;
        bus.data_in = d;
        @(posedge clk_in);
        if (!reset) begin
            if (fl) mq.delete();
            else begin
                can_wr = ins && (mq.size() < CAP);
                can_rd = rem && (mq.size() > 0);
                if (can_rd) m_dout = mq.pop_front();
                if (can_wr) mq.push_back(d);
            end
        end
        #1;
        bus.insert = 1'b0;
        bus.remove = 1'b0;
        bus.flush  = 1'b0;
    endtask

    logic [W-1:0] ord [10];
    logic [W-1:0] held;

    initial begin
        ord = '{32'hffffffff, 32'habcdefab, 32'haaaaaaaa, 32'hbabababa, 32'hcccccccc,
                32'hacacacac, 32'habdcefac, 32'h6793abcd, 32'h12345678, 32'h87654321};
        bus.insert = 0; bus.remove = 0; bus.flush = 0; bus.data_in = '0;
        #12;
        chk("rst_dout",  bus.data_out, 32'h0);
        chk("rst_empty", {31'd0, bus.empty}, 32'd1);
        chk("rst_full",  {31'd0, bus.full},  32'd0);
        @(negedge clk_in);
        reset = 1'b0;
        chk_en = 1'b1;

        // Ordering
        for (int i = 0; i < 10; i++) step(1, 0, 0, ord[i]);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, '0);
            chk("ord_dout", bus.data_out, ord[i]);
        end
        chk("ord_empty", {31'd0, bus.empty}, 32'd1);

        // Full and wrap
        for (int i = 0; i < CAP; i++) step(1, 0, 0, W'(i));
        chk("full_set", {31'd0, bus.full}, 32'd1);
        step(1, 0, 0, 32'hdeadbeef);
        chk("full_hold", {31'd0, bus.full}, 32'd1);
        for (int i = 0; i < 64; i++) begin
            step(0, 1, 0, '0);
            chk("wrap_rd1", bus.data_out, W'(i));
        end
        for (int i = 0; i < 64; i++) step(1, 0, 0, W'(1000 + i));
        for (int i = 0; i < CAP; i++) begin
            step(0, 1, 0, '0);
            chk("wrap_rd2", bus.data_out, (i < 64) ? W'(64 + i) : W'(1000 + i - 64));
        end
        chk("wrap_empty", {31'd0, bus.empty}, 32'd1);

        // Flush with a concurrent insert
        for (int i = 0; i < 3; i++) step(1, 0, 0, W'(32'h0a0a0000 + i));
        step(1, 0, 1, 32'h55555555);
        chk("fl_empty", {31'd0, bus.empty}, 32'd1);
        chk("fl_full",  {31'd0, bus.full},  32'd0);
        step(0, 1, 0, '0);
        chk("fl_dout_hold", bus.data_out, 32'd1063);
        step(1, 0, 0, 32'h0badcafe);
        step(0, 1, 0, '0);
        chk("fl_after", bus.data_out, 32'h0badcafe);

        // Simultaneous insert/remove at count=5
        for (int i = 0; i < 5; i++) step(1, 0, 0, W'(32'h50 + i));
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, W'(32'h60 + i));
            chk("sim_dout", bus.data_out, W'(32'h50 + i));
        end
        chk("sim_cnt5", W'(mq.size()), 32'd5);
        step(0, 1, 0, '0);
        chk("sim_d4", bus.data_out, 32'h54);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, '0);
            chk("sim_dn", bus.data_out, W'(32'h60 + i));
        end
        chk("sim_empty", {31'd0, bus.empty}, 32'd1);
        // Simultaneous while empty: only the insert lands
        step(1, 1, 0, 32'h77);
        chk("sim0_dout",  bus.data_out, 32'h63);
        chk("sim0_empty", {31'd0, bus.empty}, 32'd0);
        step(0, 1, 0, '0);
        chk("sim0_rd", bus.data_out, 32'h77);

        // Underflow
        step(0, 1, 0, '0);
        chk("uf_dout",  bus.data_out, 32'h77);
        chk("uf_empty", {31'd0, bus.empty}, 32'd1);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) step(1, 0, 0, W'(32'h900 + i));
        step(0, 1, 0, '0);
        @(negedge clk_in);
        #2;
        reset = 1'b1;
        mq.delete();
        m_dout = '0;
        #1;
        chk("arst_dout",  bus.data_out, 32'h0);
        chk("arst_empty", {31'd0, bus.empty}, 32'd1);
        chk("arst_full",  {31'd0, bus.full},  32'd0);
        step(1, 0, 0, 32'hfeedf00d);
        step(1, 0, 0, 32'hfeedf00d);
        @(negedge clk_in);
        reset = 1'b0;
        step(1, 0, 0, 32'h12345678);
        step(0, 1, 0, '0);
        chk("arst_rd", bus.data_out, 32'h12345678);
        chk("arst_empty2", {31'd0, bus.empty}, 32'd1);

        @(negedge clk_in);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run did not complete, expected completion");
        $fatal(1, "timeout");
    end
endmodule
